ndp_core_ctrl: RTL and testbench
================================

# ndp_core_ctrl

Parametrised load/feed controller for the near-data-processing core. It accepts a ready/valid word stream of activation and weight data and writes it layer by layer into the scratch pad through an explicit write port. It then streams the loaded layer indices into the NDP unit with backpressure and waits for the unit's calculation-done. Compared with the fixed first-generation core it adds configurable layer depth, words per layer, partial-burst handling and a feed handshake.

## Interface
- DATA_W, 32, input/scratch-pad word width
- LAYERS, 5, maximum layers held in the scratch pad (≥1)
- ACT_WORDS, 2, activation words per layer (≥1)
- WGT_BANKS, 64, weight banks per layer (≥1)
- WORDS_PER_BANK, 2, words per weight bank (≥1)
- LW, $clog2(LAYERS+1), width of layer index/count fields
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  input word valid
- in_data  in  DATA_W  input word
- in_last  in  1  final word of burst, qualified by in_valid
- in_ready  out  1  controller accepts word this cycle
- sp_we  out  1  scratch-pad write strobe
- sp_sel  out  1  0 = activation region, 1 = weight region
- sp_layer  out  LW  layer written
- sp_bank  out  $clog2(max(ACT_WORDS,WGT_BANKS))  weight bank; activation word index when sp_sel=0
- sp_addr  out  $clog2(WORDS_PER_BANK)+1  word within bank; 0 when sp_sel=0
- sp_wdata  out  DATA_W  write data
- unit_reset  out  1  NDP unit reset
- feed_valid  out  1  feed_layer valid
- feed_layer  out  LW  scratch-pad layer presented to the unit
- feed_last  out  1  final layer of this job
- feed_ready  in  1  unit accepts feed_layer
- unit_in_done  out  1  all layers fed
- unit_calc_done  in  1  unit calculation finished
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle job-complete pulse
- err_partial  out  1  last burst ended mid-layer; held until next job starts
- layers_loaded  out  LW  complete layers of current/last job

## Operation
- Accept = in_valid & in_ready. in_ready = (state is LOAD_ACT or LOAD_WGT), decoded combinationally from state.
- Words per layer W = ACT_WORDS + WGT_BANKS*WORDS_PER_BANK. Order within a layer: ACT_WORDS activation words, then weights bank-major (addr inner, bank outer).
- States:
  - IDLE: in_valid=1 → LOAD_ACT. Clears counters, err_partial and layers_loaded. No word is accepted in IDLE.
  - LOAD_ACT: an accept at activation word ACT_WORDS-1 → LOAD_WGT.
  - LOAD_WGT: an accept at bank WGT_BANKS-1, addr WORDS_PER_BANK-1 completes the layer and increments layers_loaded. Next state is FEED if in_last=1 or layers_loaded reaches LAYERS; otherwise LOAD_ACT for the next layer.
  - Early termination: an accept with in_last=1 before layer completion sets err_partial and discards the partial layer, so layers_loaded is unchanged. Next state is FEED if layers_loaded>0, else DONE.
  - FEED: unit_reset=0. feed_valid=1 and feed_layer starts at 0. On feed_valid&feed_ready the index increments. feed_last=1 when feed_layer=layers_loaded-1. Accept with feed_last → WAIT_CALC.
  - WAIT_CALC: unit_in_done=1, held. unit_calc_done=1 → DONE.
  - DONE: done=1 for one cycle. unit_reset=1 and unit_in_done=0 on the next cycle. Returns to IDLE. layers_loaded and err_partial persist.
- Scratch-pad write is registered. An accept in cycle t gives sp_we=1 in cycle t+1, with the sp_* fields for that word.
- When nothing is accepted, sp_we=0 and the other sp_* fields hold their last value.
- The unit is never released from reset when the job has zero complete layers.

## Timing
- Reset values:
  - in_ready=0, sp_we=0, sp_sel=0, sp_layer=0, sp_bank=0, sp_addr=0, sp_wdata=0
  - unit_reset=1, feed_valid=0, feed_layer=0, feed_last=0, unit_in_done=0
  - busy=0, done=0, err_partial=0, layers_loaded=0
- Reset mid-operation aborts immediately. All outputs take reset values on the next edge, and no further sp_we is issued, including any write pending from an accept in the reset cycle.
- IDLE→LOAD_ACT costs 1 cycle. With in_valid held high, one word is accepted per cycle afterwards.
- in_valid low during a load stalls without timeout. The counters hold.
- The last accepted word and entry to FEED are on the same edge. feed_valid=1 is in the cycle after the last accept.
- With feed_ready=1 throughout, FEED lasts layers_loaded cycles. feed_ready=0 holds feed_layer stable.
- unit_calc_done is ignored outside WAIT_CALC. If it is asserted on the first WAIT_CALC cycle, done is 1 cycle later.
- in_last is ignored when in_valid=0. in_last coincident with the layer-completion word is a normal finish, not an error.

## Test plan
Parameters for all scenarios: LAYERS=3, ACT_WORDS=2, WGT_BANKS=2, WORDS_PER_BANK=2, so W=6.
- Full load, 18 words, in_last on word 18 → 18 sp_we pulses, each 1 cycle after its accept. Word 7 goes to sp_sel=0, layer 1, bank 0. Word 18 goes to sp_sel=1, layer 2, bank 1, addr 1. Then feed_layer 0,1,2 with feed_last on 2, layers_loaded=3, err_partial=0.
- 12 words with in_last on word 12 → layers_loaded=2, feed 0,1, unit_in_done high until unit_calc_done, then done pulse.
- in_last on word 9 → err_partial=1, layers_loaded=1, single feed of layer 0.
- in_last on word 4 → err_partial=1, layers_loaded=0, straight to DONE, unit_reset stays 1, feed_valid never asserts.
- Toggle in_valid every other cycle and hold feed_ready=0 for 3 cycles mid-feed → write addresses and data are unchanged versus the back-to-back run, and feed_layer is held during the stall.
- Assert reset during LOAD_WGT of layer 1 and then in WAIT_CALC → outputs return to reset values next cycle, and a subsequent full load behaves as in scenario 1.

Source files
------------

// File: rtl/ndp_core_ctrl_if.sv
// ndp_core_ctrl_if: input word stream, scratch-pad write port and unit feed handshake
// Ports: in_* ready/valid input stream; sp_* registered scratch-pad write port;
// feed_* layer-index stream towards the NDP unit. slave = controller side, master = environment side.
interface ndp_core_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int LAYERS = 5,
  parameter int ACT_WORDS = 2,
  parameter int WGT_BANKS = 64,
  parameter int WORDS_PER_BANK = 2
);
  localparam int LW = $clog2(LAYERS + 1);
  localparam int NB = ACT_WORDS > WGT_BANKS ? ACT_WORDS : WGT_BANKS;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int AW = $clog2(WORDS_PER_BANK) + 1;
  logic in_valid;
  logic [DATA_W-1:0] in_data;
  logic in_last;
  logic in_ready;
  logic sp_we;
  logic sp_sel;
  logic [LW-1:0] sp_layer;
  logic [BW-1:0] sp_bank;
  logic [AW-1:0] sp_addr;
  logic [DATA_W-1:0] sp_wdata;
  logic feed_valid;
  logic [LW-1:0] feed_layer;
  logic feed_last;
  logic feed_ready;
  modport slave (
    input in_valid, in_data, in_last, feed_ready,
    output in_ready, sp_we, sp_sel, sp_layer, sp_bank, sp_addr, sp_wdata,
    output feed_valid, feed_layer, feed_last
  );
  modport master (
    output in_valid, in_data, in_last, feed_ready,
    input in_ready, sp_we, sp_sel, sp_layer, sp_bank, sp_addr, sp_wdata,
    input feed_valid, feed_layer, feed_last
  );
endinterface

// File: rtl/ndp_core_ctrl.sv
// ndp_core_ctrl: loads layers into the scratch pad, feeds layer indices to the NDP unit, waits for calc done
// Ports: clk, reset (sync, active-high); bus (ndp_core_ctrl_if.slave) carries the input stream,
// scratch-pad write port and feed handshake; unit_reset/unit_in_done/unit_calc_done talk to the unit;
// busy, done, err_partial, layers_loaded report job status.
module ndp_core_ctrl #(
  parameter int DATA_W = 32,
  parameter int LAYERS = 5,
  parameter int ACT_WORDS = 2,
  parameter int WGT_BANKS = 64,
  parameter int WORDS_PER_BANK = 2,
  parameter int LW = $clog2(LAYERS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  ndp_core_ctrl_if.slave bus,
  output logic          unit_reset,
  output logic          unit_in_done,
  input  logic          unit_calc_done,
  output logic          busy,
  output logic          done,
  output logic          err_partial,
  output logic [LW-1:0] layers_loaded
);
  localparam int NB = ACT_WORDS > WGT_BANKS ? ACT_WORDS : WGT_BANKS;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int AW = $clog2(WORDS_PER_BANK) + 1;
  typedef enum logic [2:0] {IDLE, LOAD_ACT, LOAD_WGT, FEED, WAIT_CALC, DONE} state_t;
  state_t state;
  logic [BW-1:0] act_idx, bank;
  logic [AW-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [LW-1:0] loaded_next;
  logic accept, act_end, addr_end, layer_end, go_feed, has;
  assign bus.in_ready = state == LOAD_ACT || state == LOAD_WGT;
  assign accept = bus.in_valid && bus.in_ready;
  assign act_end = act_idx == BW'(ACT_WORDS - 1);
  assign addr_end = addr == AW'(WORDS_PER_BANK - 1);
  assign layer_end = state == LOAD_WGT && bank == BW'(WGT_BANKS - 1) && addr_end;
  assign loaded_next = layers_loaded + 1'b1;
  // a completed layer ends the load on in_last or when the scratch pad is full
  assign go_feed = bus.in_last || loaded_next == LW'(LAYERS);
  assign has = layers_loaded != '0;
  assign wdata = bus.in_data;
  assign bus.feed_valid = state == FEED;
  assign bus.feed_last = bus.feed_valid && bus.feed_layer == layers_loaded - LW'(1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      act_idx <= '0;
      bank <= '0;
      addr <= '0;
      layers_loaded <= '0;
      err_partial <= 1'b0;
      unit_reset <= 1'b1;
      unit_in_done <= 1'b0;
      bus.feed_layer <= '0;
      bus.sp_we <= 1'b0;
      bus.sp_sel <= 1'b0;
      bus.sp_layer <= '0;
      bus.sp_bank <= '0;
      bus.sp_addr <= '0;
      bus.sp_wdata <= '0;
    end else begin
      bus.sp_we <= accept;
      if (accept) begin
        bus.sp_sel <= state == LOAD_WGT;
        bus.sp_layer <= layers_loaded;
        bus.sp_bank <= state == LOAD_ACT ? act_idx : bank;
        bus.sp_addr <= state == LOAD_ACT ? '0 : addr;
        bus.sp_wdata <= wdata;
      end
      case (state)
        IDLE: if (bus.in_valid) begin
          state <= LOAD_ACT;
          act_idx <= '0;
          bank <= '0;
          addr <= '0;
          layers_loaded <= '0;
          err_partial <= 1'b0;
          bus.feed_layer <= '0;
        end
        LOAD_ACT, LOAD_WGT: if (accept) begin
          if (layer_end) begin
            layers_loaded <= loaded_next;
            bank <= '0;
            addr <= '0;
            state <= go_feed ? FEED : LOAD_ACT;
            unit_reset <= !go_feed;
          end else if (bus.in_last) begin
            // partial layer is dropped; the unit stays in reset if nothing complete was loaded
            err_partial <= 1'b1;
            act_idx <= '0;
            bank <= '0;
            addr <= '0;
            state <= has ? FEED : DONE;
            unit_reset <= !has;
          end else if (state == LOAD_ACT) begin
            act_idx <= act_end ? '0 : act_idx + 1'b1;
            state <= act_end ? LOAD_WGT : LOAD_ACT;
          end else begin
            addr <= addr_end ? '0 : addr + 1'b1;
            bank <= addr_end ? bank + 1'b1 : bank;
          end
        end
        FEED: if (bus.feed_ready) begin
          if (bus.feed_last) begin
            state <= WAIT_CALC;
            unit_in_done <= 1'b1;
          end else begin
            bus.feed_layer <= bus.feed_layer + 1'b1;
          end
        end
        WAIT_CALC: if (unit_calc_done) state <= DONE;
        DONE: begin
          state <= IDLE;
          unit_reset <= 1'b1;
          unit_in_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ndp_core_ctrl.sv
// tb_ndp_core_ctrl: randomized scoreboard bench for ndp_core_ctrl against a word-index reference model
module tb_ndp_core_ctrl;
  localparam int DW = 32, L = 3, A = 2, B = 2, P = 2, W = A + B * P;
  logic clk = 0;
  logic reset = 1;
  logic unit_reset, unit_in_done, busy, done, err_partial;
  logic unit_calc_done = 0;
  logic [1:0] layers_loaded;
  always #5 clk = ~clk;
  ndp_core_ctrl_if #(.DATA_W(DW), .LAYERS(L), .ACT_WORDS(A), .WGT_BANKS(B), .WORDS_PER_BANK(P)) bus ();
  ndp_core_ctrl #(.DATA_W(DW), .LAYERS(L), .ACT_WORDS(A), .WGT_BANKS(B), .WORDS_PER_BANK(P)) dut (
    .clk(clk), .reset(reset), .bus(bus), .unit_reset(unit_reset), .unit_in_done(unit_in_done),
    .unit_calc_done(unit_calc_done), .busy(busy), .done(done), .err_partial(err_partial),
    .layers_loaded(layers_loaded)
  );
  typedef struct {logic sel; int layer; int bank; int addr; logic [DW-1:0] data; int cyc;} sp_t;
  typedef struct {int layer; logic last;} fd_t;
  sp_t sp_q[$];
  fd_t fd_q[$];
  int tests = 0, fails = 0, cyc = 0, fcount = 0, fr_mode = 0, stall = 0, flay = 0;
  bit no_unit = 0, fstall = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, longint got, longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  task automatic check_reset(string s);
    check({s, ".in_ready"}, bus.in_ready, 0);
    check({s, ".sp_we"}, bus.sp_we, 0);
    check({s, ".sp_sel"}, bus.sp_sel, 0);
    check({s, ".sp_layer"}, bus.sp_layer, 0);
    check({s, ".sp_bank"}, bus.sp_bank, 0);
    check({s, ".sp_addr"}, bus.sp_addr, 0);
    check({s, ".sp_wdata"}, bus.sp_wdata, 0);
    check({s, ".unit_reset"}, unit_reset, 1);
    check({s, ".feed_valid"}, bus.feed_valid, 0);
    check({s, ".feed_layer"}, bus.feed_layer, 0);
    check({s, ".feed_last"}, bus.feed_last, 0);
    check({s, ".unit_in_done"}, unit_in_done, 0);
    check({s, ".busy"}, busy, 0);
    check({s, ".done"}, done, 0);
    check({s, ".err_partial"}, err_partial, 0);
    check({s, ".layers_loaded"}, layers_loaded, 0);
  endtask
  // scoreboard monitor: pops expected writes and feeds whenever the DUT presents them
  always @(negedge clk) begin : mon
    sp_t e;
    fd_t f;
    if (bus.sp_we) begin
      if (sp_q.size() == 0) check("sp_we_unexpected", 1, 0);
      else begin
        e = sp_q.pop_front();
        check("sp_cycle", cyc, e.cyc);
        check("sp_sel", bus.sp_sel, e.sel);
        check("sp_layer", bus.sp_layer, e.layer);
        check("sp_bank", bus.sp_bank, e.bank);
        check("sp_addr", bus.sp_addr, e.addr);
        check("sp_wdata", bus.sp_wdata, e.data);
      end
    end
    if (bus.feed_valid) begin
      if (fstall) check("feed_hold", bus.feed_layer, flay);
      if (bus.feed_ready) begin
        check("unit_reset_in_feed", unit_reset, 0);
        if (fd_q.size() == 0) check("feed_unexpected", 1, 0);
        else begin
          f = fd_q.pop_front();
          check("feed_layer", bus.feed_layer, f.layer);
          check("feed_last", bus.feed_last, f.last);
        end
        fcount++;
      end
    end
    fstall = bus.feed_valid && !bus.feed_ready;
    flay = bus.feed_layer;
    if (no_unit) check("unit_held_in_reset", {unit_reset, bus.feed_valid}, 2);
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (fr_mode == 0) bus.feed_ready = 1;
    else if (fr_mode == 1) bus.feed_ready = 1'($urandom % 2);
    else if (fcount == 1 && stall < 3) begin
      bus.feed_ready = 0;
      stall++;
    end else bus.feed_ready = 1;
  end
  task automatic recover();
    @(posedge clk);
    #1 reset = 1;
    bus.in_valid = 0;
    unit_calc_done = 0;
    @(posedge clk);
    #1 reset = 0;
    sp_q.delete();
    fd_q.delete();
    no_unit = 0;
  endtask
  // vmode: 0 back-to-back, 1 in_valid toggles every other cycle, 2 random gaps
  task automatic run_job(int n, int vmode, int abort_at, bit abort_wait);
    int full, j, t, h;
    bit part, ok;
    sp_t e;
    full = n / W;
    part = (n % W) != 0;
    fcount = 0;
    stall = 0;
    for (int i = 0; i < full; i++) fd_q.push_back('{layer: i, last: i == full - 1});
    no_unit = full == 0;
    for (int k = 0; k < n; k++) begin
      ok = 0;
      for (t = 0; t < 100 && !ok; t++) begin
        @(posedge clk);
        #1;
        bus.in_valid = vmode == 0 ? 1'b1 : vmode == 1 ? 1'(cyc % 2) : ($urandom % 3) != 0;
        bus.in_data = $urandom;
        bus.in_last = bus.in_valid ? k == n - 1 : 1'($urandom % 2);
        unit_calc_done = vmode == 2 ? 1'($urandom % 2) : 1'b0;
        if (k == abort_at) begin
          reset = 1;
          bus.in_valid = 1;
          bus.in_last = 0;
        end
        @(negedge clk);
        if (k == abort_at) begin
          @(posedge clk);
          #1 reset = 0;
          bus.in_valid = 0;
          unit_calc_done = 0;
          @(negedge clk);
          check_reset("abort_load");
          fd_q.delete();
          no_unit = 0;
          return;
        end
        if (bus.in_valid && bus.in_ready) begin
          ok = 1;
          j = k % W;
          e.layer = k / W;
          e.sel = j >= A;
          e.bank = j < A ? j : (j - A) / P;
          e.addr = j < A ? 0 : (j - A) % P;
          e.data = bus.in_data;
          e.cyc = cyc + 1;
          sp_q.push_back(e);
        end
      end
      if (!ok) begin
        check("accept_timeout", 0, 1);
        recover();
        return;
      end
    end
    @(posedge clk);
    #1 bus.in_valid = 0;
    bus.in_last = 0;
    unit_calc_done = 0;
    @(negedge clk);
    check("feed_valid_after_last", bus.feed_valid, full > 0);
    check("done_no_layers", done, full == 0);
    if (full == 0) begin
      check("unit_reset_no_layers", unit_reset, 1);
    end else begin
      for (t = 0; t < 200 && !unit_in_done; t++) @(negedge clk);
      check("wait_unit_in_done", unit_in_done, 1);
      if (!unit_in_done) begin
        recover();
        return;
      end
      check("feeds_complete", fd_q.size(), 0);
      check("feed_count", fcount, full);
      if (abort_wait) begin
        @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check_reset("abort_wait");
        no_unit = 0;
        return;
      end
      h = $urandom_range(0, 3);
      for (int i = 0; i < h; i++) begin
        @(negedge clk);
        check("in_done_held", unit_in_done, 1);
        check("no_early_done", done, 0);
      end
      @(posedge clk);
      #1 unit_calc_done = 1;
      @(posedge clk);
      #1 unit_calc_done = 0;
      @(negedge clk);
      check("done_pulse", done, 1);
      check("busy_in_done", busy, 1);
    end
    @(negedge clk);
    check("done_cleared", done, 0);
    check("idle_not_busy", busy, 0);
    check("unit_reset_after", unit_reset, 1);
    check("in_done_after", unit_in_done, 0);
    check("layers_loaded", layers_loaded, full);
    check("err_partial", err_partial, part);
    check("writes_complete", sp_q.size(), 0);
    no_unit = 0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask
  initial begin
    bus.in_valid = 0;
    bus.in_data = 0;
    bus.in_last = 0;
    bus.feed_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk);
    #1 reset = 0;
    run_job(18, 0, -1, 0);
    run_job(12, 0, -1, 0);
    run_job(9, 0, -1, 0);
    run_job(4, 0, -1, 0);
    run_job(6, 0, -1, 0);
    run_job(1, 0, -1, 0);
    fr_mode = 2;
    run_job(18, 1, -1, 0);
    fr_mode = 0;
    run_job(18, 0, 8, 0);
    run_job(18, 0, -1, 1);
    run_job(18, 0, -1, 0);
    fr_mode = 1;
    for (int i = 0; i < 25; i++) run_job($urandom_range(1, L * W), 2, -1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
